// File: rtl/caliptra_prim_sync_filter_pkg.sv
// Helpers shared by the caliptra_prim_sync_filter slice.
// Only elaboration-time arithmetic lives here; the design declares no types of its own.
package caliptra_prim_sync_filter_pkg;

  // The persistence counter needs to reach FilterCycles-1, and it is never narrower than one bit.
  function automatic int unsigned sync_filter_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/caliptra_prim_cdc_rand_delay.sv
// Optional front-end for a synchronizer's first flop. When Enable is set, an LFSR
// decides per bit whether an input change is held back by one cycle.
module caliptra_prim_cdc_rand_delay #(
  parameter int unsigned DataWidth = 1,
  parameter bit          Enable    = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] prev_data_i,
  input  logic [DataWidth-1:0] src_data_i,
  output logic [DataWidth-1:0] dst_data_o
);

  if (Enable) begin : g_rand
    logic [15:0]          lfsr_q;
    logic [DataWidth-1:0] hold_d, hold_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lfsr_q <= 16'hace1;
        hold_q <= '0;
      end else begin
        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        hold_q <= hold_d;
      end
    end

    // A bit held back in one cycle is always passed through in the next,
    // so any change is delayed by at most one cycle.
    for (genvar i = 0; i < DataWidth; i++) begin : g_bit
      localparam int unsigned Tap = i % 16;
      assign hold_d[i] = (prev_data_i[i] != src_data_i[i]) && !hold_q[i] && lfsr_q[Tap];
    end

    assign dst_data_o = (hold_d & prev_data_i) | (~hold_d & src_data_i);
  end else begin : g_pass
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_ni, prev_data_i};
    assign dst_data_o    = src_data_i;
  end

endmodule

// File: rtl/caliptra_prim_sync_filter.sv
// Two-flop synchronizer with per-bit persistence filter and registered edge pulses.
// Define CALIPTRA_SYNC_FILTER_CDC_INSTR_EN to put caliptra_prim_cdc_rand_delay in front of q1.
module caliptra_prim_sync_filter
  import caliptra_prim_sync_filter_pkg::*;
#(
  parameter int unsigned      Width        = 1,
  parameter logic [Width-1:0] ResetValue   = '0,
  parameter int unsigned      FilterCycles = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] async_i,
  output logic [Width-1:0] sync_o,
  output logic [Width-1:0] filt_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  localparam int unsigned     CntW   = sync_filter_cnt_width(FilterCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

  if (FilterCycles == 0) begin : g_bad_cfg
    $error("caliptra_prim_sync_filter: FilterCycles must be at least 1");
  end

  logic [Width-1:0] d1, q1, q2;

`ifdef CALIPTRA_SYNC_FILTER_CDC_INSTR_EN
  caliptra_prim_cdc_rand_delay #(
    .DataWidth (Width),
    .Enable    (1'b1)
  ) u_rand_delay (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .prev_data_i (q1),
    .src_data_i  (async_i),
    .dst_data_o  (d1)
  );
`else
  assign d1 = async_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q1 <= ResetValue;
      q2 <= ResetValue;
    end else begin
      q1 <= d1;
      q2 <= q1;
    end
  end

  assign sync_o = q2;

  for (genvar i = 0; i < Width; i++) begin : g_bit
    logic [CntW-1:0] cnt_q;
    logic            filt_q, rise_q, fall_q;

    // cnt_q is cleared on the accepting cycle, so it never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q  <= '0;
        filt_q <= ResetValue[i];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (q2[i] == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CntMax) begin
          cnt_q  <= '0;
          filt_q <= q2[i];
          rise_q <= q2[i];
          fall_q <= ~q2[i];
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end

    assign filt_o[i] = filt_q;
    assign rise_o[i] = rise_q;
    assign fall_o[i] = fall_q;
  end

endmodule
